// File: rtl/domain_tdm_if.sv
// Bundle between the two distrusting sources, the TDM scheduler and the downstream domain mux.
// The master side drives the source words and out_ready. The slave side is the scheduler.
interface domain_tdm_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) ();
    logic              d1_valid;
    logic [DATA_W-1:0] d1_data;
    logic              d1_ready;
    logic              d2_valid;
    logic [DATA_W-1:0] d2_data;
    logic              d2_ready;
    logic              sel;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [CNT_W-1:0]  d1_drop_cnt;
    logic [CNT_W-1:0]  d2_drop_cnt;

    modport master (
        output d1_valid, d1_data, d2_valid, d2_data, out_ready,
        input  d1_ready, d2_ready, sel, out_valid, out_data, d1_drop_cnt, d2_drop_cnt
    );

    modport slave (
        input  d1_valid, d1_data, d2_valid, d2_data, out_ready,
        output d1_ready, d2_ready, sel, out_valid, out_data, d1_drop_cnt, d2_drop_cnt
    );
endinterface

// File: rtl/domain_tdm_sched.sv
// Fixed-schedule time-division mux of two distrusting sources onto one held word.
// A scrub phase between slots wipes the holding register so no word crosses a domain switch.
module domain_tdm_sched #(
    parameter int DATA_W       = 8,
    parameter int SLOT_LEN     = 4,
    parameter int SCRUB_CYCLES = 1,
    parameter int CNT_W        = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    domain_tdm_if.slave  bus
);
    localparam int CMAX = (SLOT_LEN > SCRUB_CYCLES) ? SLOT_LEN : SCRUB_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {
        SLOT_D1  = 2'd0,
        SCRUB_12 = 2'd1,
        SLOT_D2  = 2'd2,
        SCRUB_21 = 2'd3
    } state_t;

    state_t            state_reg;
    logic [CW-1:0]     slot_cnt_reg;
    logic              sel_reg;
    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic [CNT_W-1:0]  d1_drop_reg;
    logic [CNT_W-1:0]  d2_drop_reg;

    logic last_slot;
    logic last_scrub;
    logic room;
    logic transfer;
    logic accept;

    assign last_slot  = (slot_cnt_reg == CW'(SLOT_LEN - 1));
    assign last_scrub = (slot_cnt_reg == CW'(SCRUB_CYCLES - 1));
    assign room       = !out_valid_reg || bus.out_ready;
    assign transfer   = out_valid_reg && bus.out_ready;

    // Readies depend only on schedule position and the holding register, never on valid.
    assign bus.d1_ready = (state_reg == SLOT_D1) && !last_slot && room;
    assign bus.d2_ready = (state_reg == SLOT_D2) && !last_slot && room;
    assign accept       = (bus.d1_valid && bus.d1_ready) || (bus.d2_valid && bus.d2_ready);

    assign bus.sel         = sel_reg;
    assign bus.out_valid   = out_valid_reg;
    assign bus.out_data    = out_data_reg;
    assign bus.d1_drop_cnt = d1_drop_reg;
    assign bus.d2_drop_cnt = d2_drop_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= SLOT_D1;
            slot_cnt_reg  <= '0;
            sel_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            d1_drop_reg   <= '0;
            d2_drop_reg   <= '0;
        end else begin
            case (state_reg)
                SLOT_D1, SLOT_D2: begin
                    if (last_slot) begin
                        state_reg     <= (state_reg == SLOT_D1) ? SCRUB_12 : SCRUB_21;
                        sel_reg       <= (state_reg == SLOT_D1);
                        slot_cnt_reg  <= '0;
                        out_valid_reg <= 1'b0;
                        out_data_reg  <= '0;
                        // A word still pending here is discarded and charged to its own domain.
                        if (out_valid_reg && !bus.out_ready) begin
                            if (state_reg == SLOT_D1) begin
                                if (d1_drop_reg != '1) d1_drop_reg <= d1_drop_reg + 1'b1;
                            end else begin
                                if (d2_drop_reg != '1) d2_drop_reg <= d2_drop_reg + 1'b1;
                            end
                        end
                    end else begin
                        slot_cnt_reg <= slot_cnt_reg + 1'b1;
                        if (accept) begin
                            out_valid_reg <= 1'b1;
                            out_data_reg  <= (state_reg == SLOT_D1) ? bus.d1_data : bus.d2_data;
                        end else if (transfer) begin
                            out_valid_reg <= 1'b0;
                            out_data_reg  <= '0;
                        end
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    out_data_reg  <= '0;
                    if (last_scrub) begin
                        state_reg    <= (state_reg == SCRUB_12) ? SLOT_D2 : SLOT_D1;
                        sel_reg      <= (state_reg == SCRUB_12);
                        slot_cnt_reg <= '0;
                    end else begin
                        slot_cnt_reg <= slot_cnt_reg + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_domain_tdm_sched.sv
// Directed bench for domain_tdm_sched with SLOT_LEN=4, SCRUB_CYCLES=1 (period 10).
module tb_domain_tdm_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    domain_tdm_if #(.DATA_W(8), .CNT_W(8)) bus ();

    domain_tdm_sched #(
        .DATA_W(8), .SLOT_LEN(4), .SCRUB_CYCLES(1), .CNT_W(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Cycle 0 is the interval after reset release, before the first rising edge.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic [31:0] e_sel, e_r1, e_r2;
        int p;
        bus.d1_valid = 1'b0; bus.d1_data = '0;
        bus.d2_valid = 1'b0; bus.d2_data = '0;
        bus.out_ready = 1'b1;

        // Reset state and first D1 transfer
        do_reset();
        chk("rst_sel", bus.sel, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_d1_ready", bus.d1_ready, 1);
        chk("rst_d2_ready", bus.d2_ready, 0);
        bus.d1_valid = 1'b1; bus.d1_data = 8'hA5;
        tick(); bus.d1_valid = 1'b0; #1;
        chk("c1_out_valid", bus.out_valid, 1);
        chk("c1_out_data", bus.out_data, 8'hA5);
        tick();
        chk("c2_out_valid", bus.out_valid, 0);
        chk("c2_out_data", bus.out_data, 0);
        tick();
        chk("c3_d1_ready", bus.d1_ready, 0);
        tick();
        chk("c4_sel", bus.sel, 1);
        chk("c4_out_valid", bus.out_valid, 0);
        chk("c4_out_data", bus.out_data, 0);
        chk("c4_d1_ready", bus.d1_ready, 0);
        tick();
        chk("c5_d2_ready", bus.d2_ready, 1);
        chk("c5_sel", bus.sel, 1);

        // D2 word stranded at slot end is dropped on scrub entry
        bus.out_ready = 1'b0;
        tick(); tick();
        bus.d2_valid = 1'b1; bus.d2_data = 8'h3C; #1;
        chk("c7_d2_ready", bus.d2_ready, 1);
        tick(); bus.d2_valid = 1'b0; #1;
        chk("c8_out_valid", bus.out_valid, 1);
        chk("c8_out_data", bus.out_data, 8'h3C);
        chk("c8_d2_ready", bus.d2_ready, 0);
        tick();
        chk("c9_out_valid", bus.out_valid, 0);
        chk("c9_out_data", bus.out_data, 0);
        chk("c9_d2_drop", bus.d2_drop_cnt, 1);
        chk("c9_d1_drop", bus.d1_drop_cnt, 0);
        chk("c9_sel", bus.sel, 0);
        tick();
        chk("c10_d1_ready", bus.d1_ready, 1);

        // Schedule and readies independent of d2_valid
        bus.out_ready = 1'b1; bus.d1_valid = 1'b0; bus.d2_data = 8'h42;
        for (int r = 0; r < 2; r++) begin
            bus.d2_valid = (r == 0);
            do_reset();
            for (int c = 0; c < 10; c++) begin
                p = c % 10;
                e_sel = (p >= 4 && p <= 8) ? 1 : 0;
                e_r1  = (p < 3) ? 1 : 0;
                e_r2  = (p >= 5 && p <= 7) ? 1 : 0;
                chk($sformatf("sched_sel_r%0d", r), bus.sel, e_sel);
                chk($sformatf("sched_d1_ready_r%0d", r), bus.d1_ready, e_r1);
                chk($sformatf("sched_d2_ready_r%0d", r), bus.d2_ready, e_r2);
                tick();
            end
        end
        bus.d2_valid = 1'b0;

        // Reset in the middle of a held D2 word
        bus.out_ready = 1'b0;
        do_reset();
        bus.d1_valid = 1'b1; bus.d1_data = 8'h11;
        tick(); bus.d1_valid = 1'b0;
        tick(); tick(); tick();
        chk("rr_d1_drop", bus.d1_drop_cnt, 1);
        tick(); tick();
        bus.d2_valid = 1'b1; bus.d2_data = 8'h77;
        tick(); bus.d2_valid = 1'b0; #1;
        chk("rr_out_valid_pre", bus.out_valid, 1);
        chk("rr_out_data_pre", bus.out_data, 8'h77);
        chk("rr_sel_pre", bus.sel, 1);
        rst_n = 1'b0; #1;
        chk("rr_sel", bus.sel, 0);
        chk("rr_out_valid", bus.out_valid, 0);
        chk("rr_out_data", bus.out_data, 0);
        chk("rr_d1_drop_clr", bus.d1_drop_cnt, 0);
        chk("rr_d2_drop_clr", bus.d2_drop_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1; cyc = 0; #1;
        chk("rr_c0_sel", bus.sel, 0);
        chk("rr_c0_d1_ready", bus.d1_ready, 1);
        repeat (3) tick();
        chk("rr_c3_sel", bus.sel, 0);
        tick();
        chk("rr_c4_sel", bus.sel, 1);

        // Drop counter saturation
        do_reset();
        bus.out_ready = 1'b0; bus.d1_valid = 1'b1; bus.d1_data = 8'h5A; bus.d2_valid = 1'b0;
        while (cyc < 54) tick();
        chk("sat_d1_drop_6", bus.d1_drop_cnt, 6);
        while (cyc < 2535) tick();
        chk("sat_d1_drop_254", bus.d1_drop_cnt, 254);
        while (cyc < 3000) tick();
        chk("sat_d1_drop_255", bus.d1_drop_cnt, 255);
        chk("sat_d2_drop_0", bus.d2_drop_cnt, 0);
        bus.d1_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
